// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             busy
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg, opd_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;

  logic             accept;
  logic             is_iter;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_result;

  assign accept = in_valid && (state_reg == IDLE);
  assign shamt  = in2[SHW-1:0];

  always_comb begin
    is_iter = 1'b0;
    case (alu_control)
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: is_iter = 1'b1;
      default:                            is_iter = 1'b0;
    endcase
  end

  always_comb begin
    fast_result = '0;
    case (alu_control)
      OP_AND:  fast_result = in1 & in2;
      OP_OR:   fast_result = in1 | in2;
      OP_ADD:  fast_result = in1 + in2;
      OP_SUB:  fast_result = in1 - in2;
      OP_XOR:  fast_result = in1 ^ in2;
      OP_SLTU: fast_result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_SLT:  fast_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLL:  fast_result = in1 << shamt;
      OP_SRL:  fast_result = in1 >> shamt;
      OP_SRA:  fast_result = WIDTH'($signed(in1) >>> shamt);
      default: fast_result = '0;
    endcase
  end

  // Multiply: {hi,lo} starts as {0,B}; add A into hi when lo[0] is set, then shift right.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opd_reg} : {(WIDTH+1){1'b0}});
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

  // Restoring divide: hi holds the partial remainder, lo shifts the dividend out
  // and quotient bits in. A zero divisor always "fits", giving all-ones / A.
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;
  assign div_diff    = {1'b0, hi_reg, lo_reg[WIDTH-1]} - {2'b00, opd_reg};
  assign div_ok      = ~div_diff[WIDTH+1];
  assign div_hi_next = div_ok ? div_diff[WIDTH-1:0] : {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
  assign div_lo_next = {lo_reg[WIDTH-2:0], div_ok};

  logic             is_div;
  logic [WIDTH-1:0] hi_next, lo_next, iter_result;
  assign is_div  = (op_reg == OP_DIVU) || (op_reg == OP_REMU);
  assign hi_next = is_div ? div_hi_next : mul_hi_next;
  assign lo_next = is_div ? div_lo_next : mul_lo_next;

  always_comb begin
    iter_result = '0;
    case (op_reg)
      OP_MUL:   iter_result = lo_next;
      OP_MULHU: iter_result = hi_next;
      OP_DIVU:  iter_result = lo_next;
      OP_REMU:  iter_result = hi_next;
      default:  iter_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = is_iter ? CALC : DONE;
      CALC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    busy      = (state_reg == CALC);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opd_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
    end else if (accept) begin
      op_reg <= alu_control;
      if (is_iter) begin
        hi_reg  <= '0;
        lo_reg  <= (alu_control == OP_MUL || alu_control == OP_MULHU) ? in2 : in1;
        opd_reg <= (alu_control == OP_MUL || alu_control == OP_MULHU) ? in1 : in2;
        cnt_reg <= SHW'(WIDTH - 1);
      end else begin
        result_reg <= fast_result;
        zero_reg   <= (fast_result == '0);
      end
    end else if (state_reg == CALC) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
      if (cnt_reg == '0) begin
        result_reg <= iter_result;
        zero_reg   <= (iter_result == '0);
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign alu_result = result_reg;
  assign zero_flag  = zero_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=8: results, flags,
// latency, back-pressure, async reset and abort behaviour.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, zero_flag, busy;
  logic [31:0] in1, in2, alu_result;
  logic [3:0]  alu_control;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero_flag8, busy8;
  logic [7:0]  in1_8, in2_8, alu_result8;
  logic [3:0]  alu_control8;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .zero_flag(zero_flag), .busy(busy)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in1(in1_8), .in2(in2_8), .alu_control(alu_control8), .out_valid(out_valid8),
    .out_ready(out_ready8), .alu_result(alu_result8), .zero_flag(zero_flag8), .busy(busy8)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit noise);
    int lat;
    int busy_cnt;
    @(negedge clk);
    in1 = a; in2 = b; alu_control = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cnt++;
      if (noise) begin
        in_valid = 1'b1; in1 = ~a; in2 = 32'h1; alu_control = 4'b0010;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check_val({tag, " result"}, 64'(alu_result), 64'(exp));
    check_val({tag, " zero_flag"}, 64'(zero_flag), 64'(exp == 32'h0));
    $display("[TB] %s op=%b a=0x%08h b=0x%08h -> 0x%08h zf=%0b lat=%0d",
             tag, op, a, b, alu_result, zero_flag, lat);
    @(posedge clk); #1;
    check_val({tag, " release in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in1_8 = a; in2_8 = b; alu_control8 = op; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, " result"}, 64'(alu_result8), 64'(exp));
    check_val({tag, " zero_flag"}, 64'(zero_flag8), 64'(exp == 8'h0));
    $display("[TB] %s op=%b a=0x%02h b=0x%02h -> 0x%02h lat=%0d",
             tag, op, a, b, alu_result8, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; alu_control = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in1_8 = '0; in2_8 = '0; alu_control8 = '0;
    #12;
    check_val("reset in_ready", 64'(in_ready), 64'd1);
    check_val("reset out_valid", 64'(out_valid), 64'd0);
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset alu_result", 64'(alu_result), 64'd0);
    check_val("reset zero_flag", 64'(zero_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap with back-pressure
    @(negedge clk);
    in1 = 32'hFFFF_FFFF; in2 = 32'h1; alu_control = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("bp out_valid", 64'(out_valid), 64'd1);
      check_val("bp result", 64'(alu_result), 64'd0);
      check_val("bp zero_flag", 64'(zero_flag), 64'd1);
      check_val("bp in_ready", 64'(in_ready), 64'd0);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp release out_valid", 64'(out_valid), 64'd0);
    check_val("bp release in_ready", 64'(in_ready), 64'd1);
    $display("[TB] ADD 0xFFFFFFFF+1 with 3 cycles back-pressure -> 0x%08h", alu_result);

    run_op("AND",   4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 0);
    run_op("OR",    4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1, 0);
    run_op("XOR",   4'b0111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1, 0);
    run_op("SUB",   4'b0100, 32'd5,         32'd7,         32'hFFFF_FFFE, 1, 0);
    run_op("SLT",   4'b1001, 32'hFFFF_FFFF, 32'h1,         32'h1,         1, 0);
    run_op("SLTU",  4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1, 0);
    run_op("SLTU2", 4'b1000, 32'h1,         32'hFFFF_FFFF, 32'h1,         1, 0);
    run_op("SRA",   4'b1010, 32'h8000_0000, 32'h24,        32'hF800_0000, 1, 0);
    run_op("SRL",   4'b0101, 32'h8000_0000, 32'h24,        32'h0800_0000, 1, 0);
    run_op("SLL",   4'b0011, 32'h1,         32'd31,        32'h8000_0000, 1, 0);
    run_op("ILLEG", 4'b1110, 32'h1234_5678, 32'h1,         32'h0,         1, 0);
    run_op("MUL",   4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0);
    run_op("MULHU", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("MUL2",  4'b0110, 32'h1234_5678, 32'h10,        32'h2345_6780, 33, 0);
    run_op("MULHU2",4'b1011, 32'h1234_5678, 32'h10,        32'h0000_0001, 33, 0);
    run_op("DIVU",  4'b1100, 32'd100,       32'd7,         32'd14,        33, 0);
    run_op("REMU",  4'b1101, 32'd100,       32'd7,         32'd2,         33, 0);
    run_op("DIVU0", 4'b1100, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, 0);
    run_op("REMU0", 4'b1101, 32'd5,         32'd0,         32'd5,         33, 0);
    run_op("DIVU_NOISE", 4'b1100, 32'd100,  32'd7,         32'd14,        33, 1);

    // Async reset while DONE: outputs clear with no clock edge
    @(negedge clk);
    in1 = 32'd3; in2 = 32'd4; alu_control = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("pre-reset result", 64'(alu_result), 64'd7);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_val("async in_ready", 64'(in_ready), 64'd1);
    check_val("async out_valid", 64'(out_valid), 64'd0);
    check_val("async alu_result", 64'(alu_result), 64'd0);
    check_val("async zero_flag", 64'(zero_flag), 64'd0);
    $display("[TB] async reset during DONE -> out_valid=%0b result=0x%08h", out_valid, alu_result);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Abort a MUL mid-CALC
    @(negedge clk);
    in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; alu_control = 4'b0110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check_val("abort busy before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort busy after", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("abort no out_valid", 64'(seen), 64'd0);
    $display("[TB] MUL aborted by reset at cycle 10 -> out_valid seen=%0b", seen);
    run_op("ADD_AFTER_ABORT", 4'b0010, 32'd2, 32'd3, 32'd5, 1, 0);

    run8("W8 MUL",   4'b0110, 8'hFF, 8'hFF, 8'h01, 9);
    run8("W8 MULHU", 4'b1011, 8'hFF, 8'hFF, 8'hFE, 9);
    run8("W8 DIVU",  4'b1100, 8'd200, 8'd7, 8'd28, 9);
    run8("W8 REMU",  4'b1101, 8'd200, 8'd7, 8'd4,  9);
    run8("W8 DIVU0", 4'b1100, 8'd9,   8'd0, 8'hFF, 9);
    run8("W8 SRA",   4'b1010, 8'h80, 8'h0B, 8'hF0, 1);
    run8("W8 SLT",   4'b1001, 8'h80, 8'h01, 8'h01, 1);
    run8("W8 ADD",   4'b0010, 8'hFF, 8'h01, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
